// File: rtl/l2_pref_arbiter.sv
// l2_pref_arbiter
//   Shares the single L2 prefetch port between an instruction-side and a
//   data-side prefetcher. Each side has its own small FIFO. A round-robin
//   grant picks between them, and the winning request is held on the L2 port
//   until L2 pulses complete. Requests for a line that is already queued last
//   or already in flight are silently dropped. A prefetch that overlapped an
//   L1 demand miss is followed by a quiet backoff window.
//
// Ports
//   clk, rstn                   clock (rising edge), async active-low reset
//   ireq_valid/addr/ready       instruction prefetcher push interface
//   dreq_valid/addr/ready       data prefetcher push interface
//   req/type/addr_pref_l2cache  request to L2 (type 0 = I, 1 = D), line aligned
//   complete/hit/miss_*         L2 completion, hit flag and demand-miss flag
//   stat_hit_cnt                saturating count of prefetches that hit in L2

module l2_pref_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int LINE_OFFSET    = 6,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ireq_valid,
  input  logic [ADDR_WIDTH-1:0] ireq_addr,
  output logic                  ireq_ready,
  input  logic                  dreq_valid,
  input  logic [ADDR_WIDTH-1:0] dreq_addr,
  output logic                  dreq_ready,
  output logic                  req_pref_l2cache,
  output logic                  type_pref_l2cache,
  output logic [ADDR_WIDTH-1:0] addr_pref_l2cache,
  input  logic                  complete_l2cache_pref,
  input  logic                  hit_l2cache_pref,
  input  logic                  miss_l2cache_pref,
  output logic [15:0]           stat_hit_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFSET;

  typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;

  state_t                state;
  logic                  rr_d;
  logic                  miss_seen;
  logic [CW-1:0]         backoff_cnt;

  // Index 0 is the instruction side, index 1 the data side throughout.
  logic [ADDR_WIDTH-1:0] fifo_mem  [2][FIFO_DEPTH];
  logic [PW:0]           wr_ptr    [2];
  logic [PW:0]           rd_ptr    [2];
  logic [ADDR_WIDTH-1:0] last_line [2];
  logic [ADDR_WIDTH-1:0] push_line [2];

  logic [1:0]            push_valid;
  logic [1:0]            full;
  logic [1:0]            empty;
  logic [1:0]            push_dup;
  logic [1:0]            do_write;
  logic [1:0]            do_pop;
  logic                  grant_en;
  logic                  grant_d;
  logic [ADDR_WIDTH-1:0] head_line;

  assign ireq_ready = !full[0];
  assign dreq_ready = !full[1];

  // FIFO status, duplicate detection and grant selection. The extra pointer
  // bit distinguishes full (MSBs differ) from empty (pointers equal). A
  // duplicate push still completes the handshake but writes nothing.
  always_comb begin
    push_line[0] = ireq_addr & LINE_MASK;
    push_line[1] = dreq_addr & LINE_MASK;
    push_valid   = {dreq_valid, ireq_valid};
    full         = '0;
    empty        = '0;
    push_dup     = '0;
    do_write     = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s]    = (wr_ptr[s] == rd_ptr[s]);
      full[s]     = (wr_ptr[s][PW] != rd_ptr[s][PW]) &&
                    (wr_ptr[s][PW-1:0] == rd_ptr[s][PW-1:0]);
      push_dup[s] = ((state == REQ) && (type_pref_l2cache == s[0]) &&
                     (addr_pref_l2cache == push_line[s])) ||
                    (!empty[s] && (last_line[s] == push_line[s]));
      do_write[s] = push_valid[s] && !full[s] && !push_dup[s];
    end
    // With both sides waiting, rr_d says whether the data side goes next.
    grant_en  = (state == IDLE) && !(empty[0] && empty[1]);
    grant_d   = empty[0] ? 1'b1 : (empty[1] ? 1'b0 : rr_d);
    do_pop    = '0;
    do_pop[0] = grant_en && !grant_d;
    do_pop[1] = grant_en && grant_d;
    head_line = fifo_mem[grant_d][rd_ptr[grant_d][PW-1:0]];
  end

  // FIFO storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (do_write[s]) fifo_mem[s][wr_ptr[s][PW-1:0]] <= push_line[s];
    end
  end

  // FIFO pointers and the last-pushed line used for duplicate detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s]    <= '0;
        rd_ptr[s]    <= '0;
        last_line[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (do_write[s]) begin
          wr_ptr[s]    <= wr_ptr[s] + (PW+1)'(1);
          last_line[s] <= push_line[s];
        end
        if (do_pop[s]) rd_ptr[s] <= rd_ptr[s] + (PW+1)'(1);
      end
    end
  end

  // Arbitration FSM. The L2 port outputs are registered here and stay put
  // while a request is outstanding; addr also keeps its last value once req
  // drops. A miss seen at any point in REQ, including the complete cycle,
  // sends the FSM through BACKOFF instead of straight back to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      rr_d              <= 1'b0;
      miss_seen         <= 1'b0;
      backoff_cnt       <= '0;
      req_pref_l2cache  <= 1'b0;
      type_pref_l2cache <= 1'b0;
      addr_pref_l2cache <= '0;
      stat_hit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            req_pref_l2cache  <= 1'b1;
            type_pref_l2cache <= grant_d;
            addr_pref_l2cache <= head_line;
            rr_d              <= !grant_d;
            state             <= REQ;
          end
        end
        REQ: begin
          if (complete_l2cache_pref) begin
            req_pref_l2cache <= 1'b0;
            miss_seen        <= 1'b0;
            if (hit_l2cache_pref && (stat_hit_cnt != 16'hFFFF))
              stat_hit_cnt <= stat_hit_cnt + 16'd1;
            if ((miss_seen || miss_l2cache_pref) && (BACKOFF_CYCLES > 0)) begin
              backoff_cnt <= CW'(BACKOFF_CYCLES - 1);
              state       <= BACKOFF;
            end else begin
              state <= IDLE;
            end
          end else if (miss_l2cache_pref) begin
            miss_seen <= 1'b1;
          end
        end
        BACKOFF: begin
          if (backoff_cnt == '0) state <= IDLE;
          else                   backoff_cnt <= backoff_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_pref_arbiter.sv
// tb_l2_pref_arbiter
//   Directed bench for l2_pref_arbiter with the default parameters. Inputs
//   change 1 time unit after the rising edge and outputs are checked there,
//   so every check sees the state produced by the edge just passed.

module tb_l2_pref_arbiter;

  logic        clk;
  logic        rstn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic        dreq_ready;
  logic        req_pref_l2cache;
  logic        type_pref_l2cache;
  logic [31:0] addr_pref_l2cache;
  logic        complete_l2cache_pref;
  logic        hit_l2cache_pref;
  logic        miss_l2cache_pref;
  logic [15:0] stat_hit_cnt;

  int checks = 0;
  int errors = 0;

  l2_pref_arbiter dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .ireq_valid            (ireq_valid),
    .ireq_addr             (ireq_addr),
    .ireq_ready            (ireq_ready),
    .dreq_valid            (dreq_valid),
    .dreq_addr             (dreq_addr),
    .dreq_ready            (dreq_ready),
    .req_pref_l2cache      (req_pref_l2cache),
    .type_pref_l2cache     (type_pref_l2cache),
    .addr_pref_l2cache     (addr_pref_l2cache),
    .complete_l2cache_pref (complete_l2cache_pref),
    .hit_l2cache_pref      (hit_l2cache_pref),
    .miss_l2cache_pref     (miss_l2cache_pref),
    .stat_hit_cnt          (stat_hit_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison; failures are reported and counted.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Push on either or both sides; each requester holds its valid until it
  // sees ready at an edge. Bounded so a stuck FIFO cannot hang the run.
  task automatic applyStimulus(input logic do_i, input logic [31:0] a_i,
                               input logic do_d, input logic [31:0] a_d);
    logic pend_i, pend_d, ri, rd;
    pend_i     = do_i;
    pend_d     = do_d;
    ireq_valid = do_i;
    ireq_addr  = a_i;
    dreq_valid = do_d;
    dreq_addr  = a_d;
    for (int i = 0; i < 20 && (pend_i || pend_d); i++) begin
      ri = ireq_ready;
      rd = dreq_ready;
      step();
      if (ri) begin pend_i = 1'b0; ireq_valid = 1'b0; end
      if (rd) begin pend_d = 1'b0; dreq_valid = 1'b0; end
    end
    checkOutput("push_accepted", {31'b0, pend_i | pend_d}, 32'd0);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
  endtask

  // Single-cycle complete pulse with the given hit/miss flags.
  task automatic pulseComplete(input logic hit, input logic miss);
    complete_l2cache_pref = 1'b1;
    hit_l2cache_pref      = hit;
    miss_l2cache_pref     = miss;
    step();
    complete_l2cache_pref = 1'b0;
    hit_l2cache_pref      = 1'b0;
    miss_l2cache_pref     = 1'b0;
  endtask

  // Bounded wait for req to rise.
  task automatic waitReq(input int limit);
    for (int i = 0; i < limit && !req_pref_l2cache; i++) step();
    checkOutput("wait_req", {31'b0, req_pref_l2cache}, 32'd1);
  endtask

  logic [31:0] alt_addr [4];
  logic        alt_type [4];
  logic        alt_hit  [4];
  logic [31:0] drain    [4];
  int          high_cnt;

  initial begin
    rstn = 1'b0;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0;
    complete_l2cache_pref = 1'b0;
    hit_l2cache_pref = 1'b0;
    miss_l2cache_pref = 1'b0;

    // Reset state.
    step(); step();
    checkOutput("rst_req",    {31'b0, req_pref_l2cache}, 32'd0);
    checkOutput("rst_type",   {31'b0, type_pref_l2cache}, 32'd0);
    checkOutput("rst_addr",   addr_pref_l2cache, 32'd0);
    checkOutput("rst_stat",   {16'b0, stat_hit_cnt}, 32'd0);
    checkOutput("rst_iready", {31'b0, ireq_ready}, 32'd1);
    checkOutput("rst_dready", {31'b0, dreq_ready}, 32'd1);
    rstn = 1'b1;
    step();

    // Single I push: req two edges after the push is presented.
    $display("[TB] single instruction prefetch");
    applyStimulus(1'b1, 32'h1000_0044, 1'b0, 32'h0);
    checkOutput("t1_req_early", {31'b0, req_pref_l2cache}, 32'd0);
    step();
    checkOutput("t1_req",  {31'b0, req_pref_l2cache}, 32'd1);
    checkOutput("t1_type", {31'b0, type_pref_l2cache}, 32'd0);
    checkOutput("t1_addr", addr_pref_l2cache, 32'h1000_0040);
    pulseComplete(1'b1, 1'b0);
    checkOutput("t1_req_low",   {31'b0, req_pref_l2cache}, 32'd0);
    checkOutput("t1_addr_hold", addr_pref_l2cache, 32'h1000_0040);
    checkOutput("t1_stat",      {16'b0, stat_hit_cnt}, 32'd1);

    // Idle reset so round-robin starts from the instruction side again.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // Alternating grants I, D, I, D; hits 1,1,0,1 give a count of 3.
    $display("[TB] round-robin alternation");
    alt_addr = '{32'h3000_0000, 32'h4000_0000, 32'h3000_0040, 32'h4000_0040};
    alt_type = '{1'b0, 1'b1, 1'b0, 1'b1};
    alt_hit  = '{1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(1'b1, 32'h3000_0000, 1'b1, 32'h4000_0000);
    applyStimulus(1'b1, 32'h3000_0040, 1'b1, 32'h4000_0040);
    for (int k = 0; k < 4; k++) begin
      waitReq(10);
      checkOutput($sformatf("alt_type_%0d", k), {31'b0, type_pref_l2cache}, {31'b0, alt_type[k]});
      checkOutput($sformatf("alt_addr_%0d", k), addr_pref_l2cache, alt_addr[k]);
      step();
      checkOutput($sformatf("alt_hold_%0d", k), {31'b0, req_pref_l2cache}, 32'd1);
      pulseComplete(alt_hit[k], 1'b0);
      checkOutput($sformatf("alt_gap_%0d", k), {31'b0, req_pref_l2cache}, 32'd0);
    end
    checkOutput("alt_stat", {16'b0, stat_hit_cnt}, 32'd3);
    pulseComplete(1'b1, 1'b0);
    checkOutput("idle_complete_ignored", {16'b0, stat_hit_cnt}, 32'd3);

    // Duplicate lines: one against the queued line, one against the in-flight line.
    $display("[TB] duplicate suppression");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2000_0000);
    checkOutput("dup_dready_a", {31'b0, dreq_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2000_0010);
    checkOutput("dup_dready_b", {31'b0, dreq_ready}, 32'd1);
    checkOutput("dup_req",  {31'b0, req_pref_l2cache}, 32'd1);
    checkOutput("dup_type", {31'b0, type_pref_l2cache}, 32'd1);
    checkOutput("dup_addr", addr_pref_l2cache, 32'h2000_0000);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2000_0020);
    pulseComplete(1'b0, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (req_pref_l2cache) high_cnt++;
    end
    checkOutput("dup_no_second_req", high_cnt, 32'd0);

    // Miss during REQ: eight extra quiet cycles before the queued line issues.
    $display("[TB] miss backoff");
    applyStimulus(1'b1, 32'h5000_0000, 1'b0, 32'h0);
    step();
    checkOutput("bo_req", {31'b0, req_pref_l2cache}, 32'd1);
    miss_l2cache_pref = 1'b1;
    step();
    miss_l2cache_pref = 1'b0;
    applyStimulus(1'b1, 32'h5000_0040, 1'b0, 32'h0);
    pulseComplete(1'b0, 1'b0);
    checkOutput("bo_req_low", {31'b0, req_pref_l2cache}, 32'd0);
    high_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (req_pref_l2cache) high_cnt++;
    end
    checkOutput("bo_quiet", high_cnt, 32'd0);
    step();
    checkOutput("bo_resume",      {31'b0, req_pref_l2cache}, 32'd1);
    checkOutput("bo_resume_addr", addr_pref_l2cache, 32'h5000_0040);
    pulseComplete(1'b0, 1'b0);

    // Fill the I-FIFO while a request is stalled, then push a fifth line.
    $display("[TB] full FIFO");
    applyStimulus(1'b1, 32'h6000_0000, 1'b0, 32'h0);
    step();
    checkOutput("full_req", {31'b0, req_pref_l2cache}, 32'd1);
    applyStimulus(1'b1, 32'h6100_0000, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h6100_0040, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h6100_0080, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h6100_00C0, 1'b0, 32'h0);
    checkOutput("full_iready", {31'b0, ireq_ready}, 32'd0);
    ireq_valid = 1'b1;
    ireq_addr  = 32'h6100_0100;
    pulseComplete(1'b0, 1'b0);
    checkOutput("full_iready_idle", {31'b0, ireq_ready}, 32'd0);
    step();
    checkOutput("full_pop_req",    {31'b0, req_pref_l2cache}, 32'd1);
    checkOutput("full_pop_addr",   addr_pref_l2cache, 32'h6100_0000);
    checkOutput("full_slot_freed", {31'b0, ireq_ready}, 32'd1);
    step();
    ireq_valid = 1'b0;
    checkOutput("full_fifth_taken", {31'b0, ireq_ready}, 32'd0);
    drain = '{32'h6100_0040, 32'h6100_0080, 32'h6100_00C0, 32'h6100_0100};
    for (int k = 0; k < 4; k++) begin
      pulseComplete(1'b0, 1'b0);
      waitReq(10);
      checkOutput($sformatf("drain_addr_%0d", k), addr_pref_l2cache, drain[k]);
    end
    pulseComplete(1'b0, 1'b0);
    checkOutput("drain_iready", {31'b0, ireq_ready}, 32'd1);

    // Asynchronous reset while a request is outstanding.
    $display("[TB] reset mid-request");
    applyStimulus(1'b1, 32'h7000_0000, 1'b0, 32'h0);
    step();
    checkOutput("ar_req_before",  {31'b0, req_pref_l2cache}, 32'd1);
    checkOutput("ar_stat_before", {16'b0, stat_hit_cnt}, 32'd3);
    #2 rstn = 1'b0;
    #1;
    checkOutput("ar_req",  {31'b0, req_pref_l2cache}, 32'd0);
    checkOutput("ar_stat", {16'b0, stat_hit_cnt}, 32'd0);
    checkOutput("ar_addr", addr_pref_l2cache, 32'd0);
    step();
    rstn = 1'b1;
    step();
    checkOutput("ar_iready", {31'b0, ireq_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
